issue_queue_param: RTL and testbench
====================================

// Module: issue_queue_param
// PURPOSE
//  Parametrised collapsing (shift-down) issue queue for one execution unit of the Tomasulo core.
//  Sits between the Dispatch Unit and the Issue Unit, one instance per execution unit.
//  Holds renamed instructions and wakes operands from NUM_CDB result buses.
//  Selects the oldest ready entry for issue and squashes entries younger than a mispredicted branch.
// PARAMETERS
//  DEPTH     8  number of entries (>=4); entry 0 oldest, entry DEPTH-1 is the dispatch slot
//  PHY_W     6  physical register address width
//  TAG_W     5  ROB tag width; tag arithmetic is modulo 2^TAG_W
//  NUM_CDB   1  number of result-broadcast (wakeup) ports
// PORTS
//  Clk                      in   1              clock, rising edge
//  Reset                    in   1              synchronous, active-high
//  Cdb_PhyRegWrite          in   NUM_CDB        per-port broadcast valid
//  Cdb_RdPhyAddr            in   NUM_CDB*PHY_W  per-port broadcast destination, port k at [k*PHY_W+:PHY_W]
//  Dis_Issquenable          in   1              dispatch an instruction this cycle
//  Dis_RsDataRdy / Dis_RtDataRdy  in  1 each    source operand already available
//  Dis_RegWrite             in   1              instruction writes a destination register
//  Dis_RsPhyAddr / Dis_RtPhyAddr / Dis_NewRdPhyAddr  in  PHY_W each  renamed operands
//  Dis_RobTag               in   TAG_W          ROB tag of the dispatched instruction
//  Issque_QueueFull         out  1              dispatch must stall
//  Issque_TwoOrMoreVacant   out  1              at least 2 free entries after this cycle's issue
//  Iss_Rdy                  out  1              at least one entry ready to issue
//  Iss_Grant                in   1              Issue Unit takes the selected entry this cycle
//  Iss_RsPhyAddr / Iss_RtPhyAddr / Iss_RdPhyAddr  out  PHY_W each  selected entry fields
//  Iss_RobTag               out  TAG_W          selected entry ROB tag
//  Iss_RegWrite             out  1              selected entry write-enable
//  Cdb_Flush                in   1              branch mispredict squash
//  Rob_TopPtr / Cdb_RobDepth  in  TAG_W each    ROB head and depth of the mispredicted branch
// BEHAVIOUR
//  - Reset: every entry's valid, ready and field bits are cleared to 0 at the next edge, including mid-operation.
//    Resulting outputs: Iss_Rdy=0, Iss_* fields=0, QueueFull=0, TwoOrMoreVacant=1.
//  - Flush (combinational): entry i is squashed iff Cdb_Flush && valid[i] && (RobTag[i]-Rob_TopPtr) mod 2^TAG_W > Cdb_RobDepth.
//    Squashed entries are invalid for ready, select and occupancy in the same cycle.
//  - Dispatch: the same rule applies to Dis_RobTag; a squashed dispatch is dropped.
//  - Ready[i] = validAfterFlush[i] & RsRdy[i] & RtRdy[i]. Select = lowest ready index.
//  - Iss_* outputs are combinational from the selected entry, or from entry 0 when nothing is ready (0-cycle latency).
//  - Handshake: Iss_Grant is honoured only when Iss_Rdy=1. On a granted edge the selected entry is removed.
//    A grant while Iss_Rdy=0 is ignored and must be flagged by an assertion.
//  - Collapse: each entry i with a hole at or below it, or with the issued entry below it, takes entry i+1 at the edge.
//    Order is preserved. A queue with holes compacts one position per cycle per entry.
//  - Dispatch writes slot DEPTH-1 when that slot is free or shifting down this cycle. Dispatch is legal while full only if a grant removes an entry the same cycle.
//  - Dispatch while QueueFull=1 is dropped and flagged by an assertion.
//  - Wakeup: any port k with Cdb_PhyRegWrite[k] and a matching address sets the Rs/Rt ready bit.
//    This applies to resident entries, entries moving this cycle, and the dispatched entry (same-cycle bypass).
//  - Occupancy: Occ = popcount(validAfterFlush); Iss = Iss_Grant & Iss_Rdy.
//    QueueFull = (Occ==DEPTH) & !Iss. TwoOrMoreVacant = (Occ - Iss) <= DEPTH-2.
//  - Simultaneous flush + grant + dispatch + wakeup: flush is evaluated first, then select and grant, then the shift.
//    A flushed entry is never issued.
// CONFIGURATION
//  ISSQ_OCC_COUNT_EN defined: adds output Issque_Occupancy [$clog2(DEPTH+1)-1:0].
//    It is a register holding the post-edge entry count (0 after Reset) for performance counters.
//  Undefined: the port and register are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package tomasulo_pkg: PHY_W/TAG_W defaults, iq_entry_t struct {valid, rs_rdy, rt_rdy, regwrite, rs, rt, rd, robtag}.
//  Same package: function rob_younger(tag, top, depth) for the flush compare.
//  Sub-module issq_wakeup_cmp: per-entry CAM of one PHY_W address against NUM_CDB ports, giving one hit bit.
//  It is instantiated 2*(DEPTH+1) times.
// TESTING
//  1 Reset, dispatch Rs/Rt ready, Iss_Grant=1 next cycle -> Iss_Rdy=1, Iss_RobTag=dispatched tag; queue empty after the edge.
//  2 Fill 8 entries not ready -> QueueFull=1, TwoOrMoreVacant=0.
//    Then grant-free dispatch is dropped; a same-cycle grant plus dispatch is accepted and Occ stays 8.
//  3 Entries 2 and 5 ready -> entry 2 is selected. Grant -> entries 3..7 shift down and old entry 5 now sits at index 4.
//  4 Dispatch Rs=12 not ready while Cdb_PhyRegWrite[0]=1, Cdb_RdPhyAddr=12 -> entry enters with RsRdy=1.
//  5 Tags 3,4,7,9 with Rob_TopPtr=2, Cdb_RobDepth=4, flush -> only tags 3,4 remain. Wrap: top=30, tag 1 -> diff 3, kept.
//  6 Assert Reset mid-stream while Iss_Grant=1 -> next cycle Iss_Rdy=0, Iss_* fields 0, Occupancy=0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: issue-queue entry layout and ROB age compare.
// Entry field widths here fix the PHY_W/TAG_W that issue queues are built with.
package tomasulo_pkg;

  localparam int IQ_PHY_W = 6;
  localparam int IQ_TAG_W = 5;

  typedef struct packed {
    logic                valid;
    logic                rs_rdy;
    logic                rt_rdy;
    logic                regwrite;
    logic [IQ_PHY_W-1:0] rs;
    logic [IQ_PHY_W-1:0] rt;
    logic [IQ_PHY_W-1:0] rd;
    logic [IQ_TAG_W-1:0] robtag;
  } iq_entry_t;

  // True when tag lies beyond the mispredicted branch, measured from the ROB head (mod 2^TAG_W).
  function automatic logic rob_younger(input logic [IQ_TAG_W-1:0] tag,
                                       input logic [IQ_TAG_W-1:0] top,
                                       input logic [IQ_TAG_W-1:0] depth);
    logic [IQ_TAG_W-1:0] diff;
    diff = tag - top;
    return diff > depth;
  endfunction

endpackage

// File: rtl/issq_wakeup_cmp.sv
// Wakeup CAM cell: matches one physical register address against all result buses.
module issq_wakeup_cmp
  import tomasulo_pkg::*;
#(
  parameter int PHY_W   = IQ_PHY_W,
  parameter int NUM_CDB = 1
) (
  input  logic [PHY_W-1:0]         PhyAddr,
  input  logic [NUM_CDB-1:0]       CdbWrite,
  input  logic [NUM_CDB*PHY_W-1:0] CdbAddr,
  output logic                     Hit
);

  logic [NUM_CDB-1:0] portHit;

  for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_port
    assign portHit[gi] = CdbWrite[gi] && (CdbAddr[gi*PHY_W +: PHY_W] == PhyAddr);
  end

  assign Hit = |portHit;

endmodule

// File: rtl/issue_queue_param.sv
// Collapsing issue queue with CDB wakeup, oldest-ready select and branch squash.
// Optional ISSQ_OCC_COUNT_EN adds a registered Issque_Occupancy output.
module issue_queue_param
  import tomasulo_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int PHY_W   = IQ_PHY_W,
  parameter int TAG_W   = IQ_TAG_W,
  parameter int NUM_CDB = 1
) (
  input  logic                     Clk,
`ifdef ISSQ_OCC_COUNT_EN
  output logic [$clog2(DEPTH+1)-1:0] Issque_Occupancy,
`endif
  input  logic                     Reset,
  input  logic [NUM_CDB-1:0]       Cdb_PhyRegWrite,
  input  logic [NUM_CDB*PHY_W-1:0] Cdb_RdPhyAddr,
  input  logic                     Dis_Issquenable,
  input  logic                     Dis_RsDataRdy,
  input  logic                     Dis_RtDataRdy,
  input  logic                     Dis_RegWrite,
  input  logic [PHY_W-1:0]         Dis_RsPhyAddr,
  input  logic [PHY_W-1:0]         Dis_RtPhyAddr,
  input  logic [PHY_W-1:0]         Dis_NewRdPhyAddr,
  input  logic [TAG_W-1:0]         Dis_RobTag,
  output logic                     Issque_QueueFull,
  output logic                     Issque_TwoOrMoreVacant,
  output logic                     Iss_Rdy,
  input  logic                     Iss_Grant,
  output logic [PHY_W-1:0]         Iss_RsPhyAddr,
  output logic [PHY_W-1:0]         Iss_RtPhyAddr,
  output logic [PHY_W-1:0]         Iss_RdPhyAddr,
  output logic [TAG_W-1:0]         Iss_RobTag,
  output logic                     Iss_RegWrite,
  input  logic                     Cdb_Flush,
  input  logic [TAG_W-1:0]         Rob_TopPtr,
  input  logic [TAG_W-1:0]         Cdb_RobDepth
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int SEL_W = $clog2(DEPTH);

  iq_entry_t entryReg  [DEPTH];
  iq_entry_t entryNext [DEPTH];
  iq_entry_t upd       [DEPTH];
  iq_entry_t disEntry;

  logic [DEPTH-1:0] validAf, ready, issueOh, shiftDn;
  logic [DEPTH:0]   wakeRs, wakeRt;
  logic [PHY_W-1:0] rsAddr [DEPTH+1];
  logic [PHY_W-1:0] rtAddr [DEPTH+1];
  logic [SEL_W-1:0] selIdx;
  logic [OCC_W-1:0] occ;
  logic             issRdy, issue;

  // Comparator slot DEPTH serves the incoming dispatch (same-cycle bypass).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr
    assign rsAddr[gi] = entryReg[gi].rs;
    assign rtAddr[gi] = entryReg[gi].rt;
  end
  assign rsAddr[DEPTH] = Dis_RsPhyAddr;
  assign rtAddr[DEPTH] = Dis_RtPhyAddr;

  for (genvar gi = 0; gi <= DEPTH; gi++) begin : g_wake
    issq_wakeup_cmp #(.PHY_W(PHY_W), .NUM_CDB(NUM_CDB)) u_rs (
      .PhyAddr (rsAddr[gi]),
      .CdbWrite(Cdb_PhyRegWrite),
      .CdbAddr (Cdb_RdPhyAddr),
      .Hit     (wakeRs[gi])
    );
    issq_wakeup_cmp #(.PHY_W(PHY_W), .NUM_CDB(NUM_CDB)) u_rt (
      .PhyAddr (rtAddr[gi]),
      .CdbWrite(Cdb_PhyRegWrite),
      .CdbAddr (Cdb_RdPhyAddr),
      .Hit     (wakeRt[gi])
    );
  end

  always_comb begin
    validAf = '0;
    ready   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      validAf[i] = entryReg[i].valid &
                   ~(Cdb_Flush & rob_younger(entryReg[i].robtag, Rob_TopPtr, Cdb_RobDepth));
      ready[i]   = validAf[i] & entryReg[i].rs_rdy & entryReg[i].rt_rdy;
    end
  end

  always_comb begin
    selIdx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ready[i]) selIdx = SEL_W'(i);
    end
  end

  assign issRdy = |ready;
  assign issue  = Iss_Grant & issRdy;

  // An entry moves down whenever anything at or below it is empty or leaving.
  always_comb begin
    logic run;
    run     = 1'b0;
    issueOh = '0;
    shiftDn = '0;
    occ     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issueOh[i]    = issue & (selIdx == SEL_W'(i));
      run           = run | ~validAf[i] | issueOh[i];
      shiftDn[i]    = run;
      occ           = occ + OCC_W'(validAf[i]);
      upd[i]        = entryReg[i];
      upd[i].valid  = validAf[i] & ~issueOh[i];
      upd[i].rs_rdy = entryReg[i].rs_rdy | wakeRs[i];
      upd[i].rt_rdy = entryReg[i].rt_rdy | wakeRt[i];
    end
  end

  assign Issque_QueueFull       = (occ == OCC_W'(DEPTH)) & ~issue;
  assign Issque_TwoOrMoreVacant = (occ - OCC_W'(issue)) <= OCC_W'(DEPTH-2);

  always_comb begin
    disEntry.valid    = Dis_Issquenable & ~Issque_QueueFull &
                        ~(Cdb_Flush & rob_younger(Dis_RobTag, Rob_TopPtr, Cdb_RobDepth));
    disEntry.rs_rdy   = Dis_RsDataRdy | wakeRs[DEPTH];
    disEntry.rt_rdy   = Dis_RtDataRdy | wakeRt[DEPTH];
    disEntry.regwrite = Dis_RegWrite;
    disEntry.rs       = Dis_RsPhyAddr;
    disEntry.rt       = Dis_RtPhyAddr;
    disEntry.rd       = Dis_NewRdPhyAddr;
    disEntry.robtag   = Dis_RobTag;
    for (int i = 0; i < DEPTH-1; i++) begin
      entryNext[i] = shiftDn[i] ? upd[i+1] : upd[i];
    end
    entryNext[DEPTH-1] = shiftDn[DEPTH-1] ? disEntry : upd[DEPTH-1];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) entryReg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entryReg[i] <= entryNext[i];
    end
  end

  assign Iss_Rdy       = issRdy;
  assign Iss_RsPhyAddr = entryReg[selIdx].rs;
  assign Iss_RtPhyAddr = entryReg[selIdx].rt;
  assign Iss_RdPhyAddr = entryReg[selIdx].rd;
  assign Iss_RobTag    = entryReg[selIdx].robtag;
  assign Iss_RegWrite  = entryReg[selIdx].regwrite;

`ifdef ISSQ_OCC_COUNT_EN
  logic [OCC_W-1:0] occReg;
  always_ff @(posedge Clk) begin
    if (Reset) occReg <= '0;
    else       occReg <= occ - OCC_W'(issue) + OCC_W'(disEntry.valid);
  end
  assign Issque_Occupancy = occReg;
`endif

  a_grant_needs_rdy : assert property (@(posedge Clk) disable iff (Reset)
    Iss_Grant |-> issRdy) else $error("Iss_Grant while Iss_Rdy=0");

  a_no_dispatch_full : assert property (@(posedge Clk) disable iff (Reset)
    Dis_Issquenable |-> !Issque_QueueFull) else $error("dispatch while queue full");

endmodule

// File: tb/tb_issue_queue_param.sv
// Scoreboard bench for issue_queue_param: expected issues queued at stimulus, checked at grant.
module tb_issue_queue_param;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [0:0] Cdb_PhyRegWrite;
  logic [5:0] Cdb_RdPhyAddr;
  logic       Dis_Issquenable, Dis_RsDataRdy, Dis_RtDataRdy, Dis_RegWrite;
  logic [5:0] Dis_RsPhyAddr, Dis_RtPhyAddr, Dis_NewRdPhyAddr;
  logic [4:0] Dis_RobTag;
  logic       Issque_QueueFull, Issque_TwoOrMoreVacant, Iss_Rdy, Iss_Grant;
  logic [5:0] Iss_RsPhyAddr, Iss_RtPhyAddr, Iss_RdPhyAddr;
  logic [4:0] Iss_RobTag;
  logic       Iss_RegWrite;
  logic       Cdb_Flush;
  logic [4:0] Rob_TopPtr, Cdb_RobDepth;
`ifdef ISSQ_OCC_COUNT_EN
  logic [3:0] Issque_Occupancy;
`endif

  issue_queue_param dut (
    .Clk(Clk),
`ifdef ISSQ_OCC_COUNT_EN
    .Issque_Occupancy(Issque_Occupancy),
`endif
    .Reset(Reset),
    .Cdb_PhyRegWrite(Cdb_PhyRegWrite), .Cdb_RdPhyAddr(Cdb_RdPhyAddr),
    .Dis_Issquenable(Dis_Issquenable), .Dis_RsDataRdy(Dis_RsDataRdy),
    .Dis_RtDataRdy(Dis_RtDataRdy), .Dis_RegWrite(Dis_RegWrite),
    .Dis_RsPhyAddr(Dis_RsPhyAddr), .Dis_RtPhyAddr(Dis_RtPhyAddr),
    .Dis_NewRdPhyAddr(Dis_NewRdPhyAddr), .Dis_RobTag(Dis_RobTag),
    .Issque_QueueFull(Issque_QueueFull), .Issque_TwoOrMoreVacant(Issque_TwoOrMoreVacant),
    .Iss_Rdy(Iss_Rdy), .Iss_Grant(Iss_Grant),
    .Iss_RsPhyAddr(Iss_RsPhyAddr), .Iss_RtPhyAddr(Iss_RtPhyAddr),
    .Iss_RdPhyAddr(Iss_RdPhyAddr), .Iss_RobTag(Iss_RobTag), .Iss_RegWrite(Iss_RegWrite),
    .Cdb_Flush(Cdb_Flush), .Rob_TopPtr(Rob_TopPtr), .Cdb_RobDepth(Cdb_RobDepth)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] tag;
    logic [5:0] rs;
    logic [5:0] rd;
    logic       rw;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic clear_inputs();
    Cdb_PhyRegWrite = 1'b0; Cdb_RdPhyAddr = '0;
    Dis_Issquenable = 1'b0; Dis_RsDataRdy = 1'b0; Dis_RtDataRdy = 1'b0; Dis_RegWrite = 1'b0;
    Dis_RsPhyAddr = '0; Dis_RtPhyAddr = '0; Dis_NewRdPhyAddr = '0; Dis_RobTag = '0;
    Iss_Grant = 1'b0; Cdb_Flush = 1'b0; Rob_TopPtr = '0; Cdb_RobDepth = '0;
  endtask

  // Regwrite follows rd[0] so both polarities appear on Iss_RegWrite.
  task automatic set_dis(input logic [4:0] tag, input logic [5:0] rs, input logic [5:0] rt,
                         input logic [5:0] rd, input logic rsr, input logic rtr, input bit expect_issue);
    sb_t e;
    Dis_Issquenable = 1'b1; Dis_RobTag = tag;
    Dis_RsPhyAddr = rs; Dis_RtPhyAddr = rt; Dis_NewRdPhyAddr = rd;
    Dis_RsDataRdy = rsr; Dis_RtDataRdy = rtr; Dis_RegWrite = rd[0];
    if (expect_issue) begin
      e.tag = tag; e.rs = rs; e.rd = rd; e.rw = rd[0];
      sb_q.push_back(e);
    end
  endtask

  task automatic stop_dis();
    Dis_Issquenable = 1'b0;
    Cdb_PhyRegWrite = 1'b0;
  endtask

  task automatic grant_one();
    sb_t e;
    #1;
    check("iss_rdy", Iss_Rdy, 1);
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: got issue of tag %0d, expected none", Iss_RobTag);
    end else begin
      e = sb_q.pop_front();
      check("iss_tag", Iss_RobTag, e.tag);
      check("iss_rs", Iss_RsPhyAddr, e.rs);
      check("iss_rd", Iss_RdPhyAddr, e.rd);
      check("iss_rw", Iss_RegWrite, e.rw);
    end
    Iss_Grant = 1'b1;
    #1;
    check("full_with_grant", Issque_QueueFull, 0);
    tick();
    Iss_Grant = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    check({tag, "_rdy"}, Iss_Rdy, 0);
    check({tag, "_tag"}, Iss_RobTag, 0);
    check({tag, "_rs"}, Iss_RsPhyAddr, 0);
    check({tag, "_rt"}, Iss_RtPhyAddr, 0);
    check({tag, "_rd"}, Iss_RdPhyAddr, 0);
    check({tag, "_rw"}, Iss_RegWrite, 0);
    check({tag, "_full"}, Issque_QueueFull, 0);
    check({tag, "_two"}, Issque_TwoOrMoreVacant, 1);
`ifdef ISSQ_OCC_COUNT_EN
    check({tag, "_occ"}, Issque_Occupancy, 0);
`endif
  endtask

  initial begin
    clear_inputs();
    Reset = 1'b1;
    @(negedge Clk);
    tick();
    Reset = 1'b0;
    check_reset_state("reset");

    // 1: single ready dispatch, granted next cycle, queue empty afterwards
    set_dis(5'd5, 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 1'b1);
    tick();
    stop_dis();
    grant_one();
    #1;
    check("t1_empty_rdy", Iss_Rdy, 0);
    check("t1_empty_two", Issque_TwoOrMoreVacant, 1);

    // 2/3: fill eight entries; only the 3rd and 6th oldest are ready
    for (int i = 0; i < 8; i++) begin
      set_dis(5'(10 + i), 6'(40 + i), 6'(50 + i), 6'(i), (i == 2 || i == 5), (i == 2 || i == 5),
              (i == 2 || i == 5));
      tick();
    end
    stop_dis();
    #1;
    check("fill_full", Issque_QueueFull, 1);
    check("fill_two", Issque_TwoOrMoreVacant, 0);
`ifdef ISSQ_OCC_COUNT_EN
    check("fill_occ", Issque_Occupancy, 8);
`endif

    // Dispatch into a full queue without grant must be dropped (would be ready if it leaked)
    $assertoff;
    set_dis(5'd20, 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 1'b0);
    #1;
    check("drop_full", Issque_QueueFull, 1);
    tick();
    stop_dis();
    $asserton;
    #1;
    check("drop_still_full", Issque_QueueFull, 1);

    // Grant plus dispatch while full: accepted, occupancy stays at DEPTH
    set_dis(5'd21, 6'd60, 6'd61, 6'd7, 1'b0, 1'b0, 1'b0);
    grant_one();
    stop_dis();
    #1;
    check("swap_full", Issque_QueueFull, 1);
`ifdef ISSQ_OCC_COUNT_EN
    check("swap_occ", Issque_Occupancy, 8);
`endif
    grant_one();
    #1;
    check("none_ready", Iss_Rdy, 0);

    // Wake the remaining entries over the CDB, then drain in age order
    for (int a = 40; a <= 61; a++) begin
      Cdb_PhyRegWrite = 1'b1; Cdb_RdPhyAddr = 6'(a);
      tick();
    end
    stop_dis();
    for (int i = 0; i < 8; i++) begin
      sb_t e;
      if (i != 2 && i != 5) begin
        e.tag = 5'(10 + i); e.rs = 6'(40 + i); e.rd = 6'(i); e.rw = i[0];
        sb_q.push_back(e);
      end
    end
    begin
      sb_t e;
      e.tag = 5'd21; e.rs = 6'd60; e.rd = 6'd7; e.rw = 1'b1;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 7; i++) grant_one();
    #1;
    check("drained_rdy", Iss_Rdy, 0);
    check("drained_two", Issque_TwoOrMoreVacant, 1);

    // 4: same-cycle wakeup of the dispatched entry
    set_dis(5'd25, 6'd12, 6'd13, 6'd9, 1'b0, 1'b1, 1'b1);
    Cdb_PhyRegWrite = 1'b1; Cdb_RdPhyAddr = 6'd12;
    tick();
    stop_dis();
    grant_one();

    // 5: flush squashes tags 7 and 9 (and a dispatched tag 8) relative to top=2, depth=4
    set_dis(5'd3, 6'd21, 6'd22, 6'd1, 1'b1, 1'b1, 1'b1); tick();
    set_dis(5'd4, 6'd23, 6'd24, 6'd2, 1'b1, 1'b1, 1'b1); tick();
    set_dis(5'd7, 6'd25, 6'd26, 6'd3, 1'b1, 1'b1, 1'b0); tick();
    set_dis(5'd9, 6'd27, 6'd28, 6'd4, 1'b1, 1'b1, 1'b0); tick();
    set_dis(5'd8, 6'd29, 6'd30, 6'd5, 1'b1, 1'b1, 1'b0);
    Cdb_Flush = 1'b1; Rob_TopPtr = 5'd2; Cdb_RobDepth = 5'd4;
    #1;
    check("flush_two", Issque_TwoOrMoreVacant, 1);
    tick();
    stop_dis();
    Cdb_Flush = 1'b0;
    grant_one();
    grant_one();
    #1;
    check("flush_gone", Iss_Rdy, 0);

    // Wrap: top=30, tag 1 kept (diff 3); older tag 28 squashed in the same cycle as the grant
    set_dis(5'd28, 6'd31, 6'd32, 6'd6, 1'b1, 1'b1, 1'b0); tick();
    set_dis(5'd1, 6'd33, 6'd34, 6'd8, 1'b1, 1'b1, 1'b1); tick();
    stop_dis();
    Cdb_Flush = 1'b1; Rob_TopPtr = 5'd30; Cdb_RobDepth = 5'd4;
    grant_one();
    Cdb_Flush = 1'b0;
    #1;
    check("wrap_gone", Iss_Rdy, 0);

    // 6: reset mid-stream while granting
    set_dis(5'd6, 6'd35, 6'd36, 6'd11, 1'b1, 1'b1, 1'b0); tick();
    set_dis(5'd7, 6'd37, 6'd38, 6'd12, 1'b1, 1'b1, 1'b0); tick();
    stop_dis();
    #1;
    check("pre_reset_rdy", Iss_Rdy, 1);
    Reset = 1'b1; Iss_Grant = 1'b1;
    tick();
    Reset = 1'b0; Iss_Grant = 1'b0;
    check_reset_state("midreset");

    check("sb_left", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
